// File: rtl/picomips_pkg.sv
// Shared types and sizing for the picoMIPS fetch path.
// Sequencer states, PC-mux selects and default widths live here.
`ifndef PROGRAM_CODE_SIZE
`define PROGRAM_CODE_SIZE 4
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 24
`endif

package picomips_pkg;

   localparam int PROGRAM_CODE_SIZE = `PROGRAM_CODE_SIZE;
   localparam int INSTRUCTION_SIZE  = `INSTRUCTION_SIZE;
   localparam int PC_MAX = (1 << PROGRAM_CODE_SIZE) - 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STEP,
      HALTED
   } seq_state_t;

   typedef enum logic [2:0] {
      PC_HOLD,
      PC_INC,
      PC_ABS,
      PC_REL,
      PC_CLR
   } pc_sel_t;

endpackage

// File: rtl/program_sequencer_if.sv
// Bus between the sequencer, program memory and the decoder.
// master = sequencer side, slave = memory/decoder side.
interface program_sequencer_if #(
   parameter int program_code_size = 4,
   parameter int instruction_size  = 24
);

   logic                         start;
   logic                         step_mode;
   logic                         step;
   logic                         stall;
   logic                         branch_abs;
   logic                         branch_rel;
   logic [program_code_size-1:0] branch_target;
   logic                         halt;
   logic [instruction_size-1:0]  instruction_code;
   logic [program_code_size-1:0] address;
   logic [instruction_size-1:0]  instr_out;
   logic [program_code_size-1:0] instr_pc;
   logic                         instr_valid;
   logic                         running;
   logic                         halted;
   logic                         wrapped;

   modport master (
      input  start, step_mode, step, stall,
      input  branch_abs, branch_rel, branch_target, halt,
      input  instruction_code,
      output address, instr_out, instr_pc, instr_valid,
      output running, halted, wrapped
   );

   modport slave (
      output start, step_mode, step, stall,
      output branch_abs, branch_rel, branch_target, halt,
      output instruction_code,
      input  address, instr_out, instr_pc, instr_valid,
      input  running, halted, wrapped
   );

endinterface

// File: rtl/pc_unit.sv
// Program counter with next-PC mux and sticky wrap flag.
// A wrap is only an increment out of the top address.
module pc_unit
   import picomips_pkg::*;
#(
   parameter int program_code_size = PROGRAM_CODE_SIZE
) (
   input  logic                         clk,
   input  logic                         n_reset,
   input  pc_sel_t                      sel,
   input  logic [program_code_size-1:0] target,
   input  logic [program_code_size-1:0] base,
   output logic [program_code_size-1:0] pc,
   output logic                         wrapped
);

   localparam logic [program_code_size-1:0] LAST = '1;

   logic [program_code_size-1:0] pc_next;
   logic                         wrap_set;

   // next-PC selection; relative target is two's-complement modulo width
   always_comb begin
      pc_next = pc;
      unique case (sel)
         PC_HOLD: pc_next = pc;
         PC_INC:  pc_next = pc + 1'b1;
         PC_ABS:  pc_next = target;
         PC_REL:  pc_next = base + target;
         PC_CLR:  pc_next = '0;
         default: pc_next = pc;
      endcase
   end

   assign wrap_set = (sel == PC_INC) && (pc == LAST);

   // PC register and sticky wrap flag
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         pc      <= '0;
         wrapped <= 1'b0;
      end else begin
         pc <= pc_next;
         if (sel == PC_CLR)
            wrapped <= 1'b0;
         else if (wrap_set)
            wrapped <= 1'b1;
      end
   end

endmodule

// File: rtl/program_sequencer.sv
// picoMIPS fetch controller: run/step/halt FSM and fetch register.
// Branches squash the word fetched in the same cycle.
module program_sequencer
   import picomips_pkg::*;
#(
   parameter int program_code_size = PROGRAM_CODE_SIZE,
   parameter int instruction_size  = INSTRUCTION_SIZE
) (
   input logic clk,
   input logic n_reset,
   program_sequencer_if.master bus
);

   seq_state_t state;
   seq_state_t state_next;
   seq_state_t mode_state;
   pc_sel_t    pc_sel;

   logic [program_code_size-1:0] pc;
   logic [instruction_size-1:0]  instr_q;
   logic [program_code_size-1:0] instr_pc_q;
   logic                         valid_q;
   logic                         valid_next;
   logic                         fetch;
   logic                         advance;
   logic                         consume;
   logic                         running_q;
   logic                         halted_q;
   logic                         wrapped;

   pc_unit #(
      .program_code_size(program_code_size)
   ) u_pc (
      .clk     (clk),
      .n_reset (n_reset),
      .sel     (pc_sel),
      .target  (bus.branch_target),
      .base    (instr_pc_q),
      .pc      (pc),
      .wrapped (wrapped)
   );

   assign advance = !bus.stall &&
                    ((state == RUN) ||
                     (state == STEP && bus.step));
   assign consume = valid_q && advance;
   assign mode_state = bus.step_mode ? STEP : RUN;

   // next state, PC select and fetch control; start wins over all
   always_comb begin
      state_next = state;
      pc_sel     = PC_HOLD;
      fetch      = 1'b0;
      valid_next = valid_q;
      unique case (state)
         IDLE, HALTED: begin
            valid_next = 1'b0;
            if (bus.start) begin
               state_next = mode_state;
               pc_sel     = PC_CLR;
            end
         end
         RUN, STEP: begin
            state_next = mode_state;
            if (bus.start) begin
               pc_sel     = PC_CLR;
               valid_next = 1'b0;
            end else if (consume && bus.halt) begin
               state_next = HALTED;
               valid_next = 1'b0;
            end else if (advance) begin
               fetch      = 1'b1;
               valid_next = 1'b1;
               pc_sel     = PC_INC;
               if (consume && bus.branch_abs) begin
                  pc_sel     = PC_ABS;
                  valid_next = 1'b0;
               end else if (consume && bus.branch_rel) begin
                  pc_sel     = PC_REL;
                  valid_next = 1'b0;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // state register with registered status decode
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state     <= IDLE;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state     <= state_next;
         running_q <= (state_next == RUN) || (state_next == STEP);
         halted_q  <= (state_next == HALTED);
      end
   end

   // fetch/decode stage register
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         valid_q <= valid_next;
         if (fetch) begin
            instr_q    <= bus.instruction_code;
            instr_pc_q <= pc;
         end
      end
   end

   assign bus.address     = pc;
   assign bus.instr_out   = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = valid_q;
   assign bus.running     = running_q;
   assign bus.halted      = halted_q;
   assign bus.wrapped     = wrapped;

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Fetch controller for the picoMIPS core.
- Owns the program counter and drives the address input of program_memory, which is a combinational read.
- Registers the returned instruction word into a single fetch/decode stage register for the decoder.
- Handles run/single-step/halt sequencing, stall hold, and absolute or relative branches with a one-cycle squash.

Parameters:
- program_code_size, `PROGRAM_CODE_SIZE, PC/address width; program space is 2^program_code_size words.
- instruction_size, `INSTRUCTION_SIZE, instruction word width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins or restarts execution from address 0.
- step_mode  input  1  level; 1 = single-step mode, 0 = free-run mode.
- step  input  1  in single-step mode, each cycle it is high permits one fetch.
- stall  input  1  level; freezes the PC and the fetch register.
- branch_abs  input  1  decoder request: absolute branch for the instruction currently presented.
- branch_rel  input  1  decoder request: relative branch for the instruction currently presented.
- branch_target  input  program_code_size  absolute target, or two's-complement offset for a relative branch.
- halt  input  1  decoder flags the presented instruction as a halt.
- instruction_code  input  instruction_size  word read from program_memory.
- address  output  program_code_size  current PC, to program_memory.
- instr_out  output  instruction_size  registered instruction presented to the decoder.
- instr_pc  output  program_code_size  address that instr_out was fetched from.
- instr_valid  output  1  instr_out is valid.
- running  output  1  high in RUN or STEP.
- halted  output  1  high in HALTED.
- wrapped  output  1  sticky; the PC has wrapped past its maximum address.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state = IDLE; pc, instr_out, instr_pc = 0.
  - instr_valid, running, halted, wrapped = 0.
- address always equals pc; it is not registered a second time.
- States: IDLE, RUN, STEP, HALTED.
- IDLE: pc held at 0, instr_valid = 0. On start, go to STEP if step_mode = 1, otherwise RUN.
- advance definition:
  - RUN: advance = !stall.
  - STEP: advance = step & !stall.
  - All other states: advance = 0.
- Fetch on an advance cycle:
  - instr_out <= instruction_code; instr_pc <= pc; instr_valid <= 1.
  - pc <= pc + 1, modulo 2^program_code_size.
  - Fetch latency: the word at address A appears on instr_out the cycle after the PC equals A and advance is high.
- Non-advance cycle: pc, instr_out, instr_pc and instr_valid all hold their values. There is no bubble insertion during a stall.
- consume = instr_valid & advance.
- Actions on consume, in priority order (halt > branch_abs > branch_rel):
  - halt: state <= HALTED; instr_valid <= 0; pc holds; no fetch.
  - branch_abs: pc <= branch_target; instr_valid <= 0 (squash the word fetched this cycle).
  - branch_rel: pc <= instr_pc + branch_target (signed offset, result modulo 2^program_code_size); instr_valid <= 0.
- Branch or halt inputs are ignored when instr_valid = 0 or advance = 0.
- Mode switching: step_mode changes take effect between RUN and STEP on the next edge, with pc and the fetch register unchanged.
- HALTED: everything holds; instr_valid = 0. On start: pc <= 0, wrapped <= 0, state <= RUN or STEP according to step_mode.
- start in RUN or STEP: restart. pc <= 0, instr_valid <= 0, wrapped <= 0. Start has priority over same-cycle fetch, branch and halt.
- wrapped: set when an increment (not a branch) moves the pc from 2^program_code_size - 1 to 0. Cleared only by reset or start.
- running and halted are registered and decoded from state.

Decomposition:
- Shared package picomips_pkg holds:
  - typedef enum logic [1:0] seq_state_t {IDLE, RUN, STEP, HALTED}.
  - Localparam PC_MAX derived from program_code_size.
- One natural sub-module, pc_unit: the PC register, next-PC mux (hold / increment / absolute / relative / clear) and wrapped flag.
- program_sequencer contains the FSM and the fetch register.

Test Plan (program_code_size = 4, instruction_size = 24, memory word k = k):
- Free run: reset, start with step_mode = 0 -> instr_out 0, 1, 2 ... on consecutive cycles from the cycle after start+1; instr_valid = 1; instr_pc equals instr_out.
- Stall: assert stall for 3 cycles while instr_out = 5 -> instr_out, instr_pc and address frozen at 5/5/6; resumes with 6 the cycle after stall drops.
- Branches:
  - branch_abs = 1, target 12, while instr_out = 3 -> next cycle instr_valid = 0; then instr_out = 12.
  - branch_rel with offset 4'b1110 while instr_pc = 9 -> squash, then instr_out = 7.
- Wrap and halt: run through 15 -> 0 and check wrapped = 1. Then halt = 1 at instr_pc = 2 -> halted = 1, running = 0, instr_valid = 0, address held at 3. Then start -> pc 0, wrapped = 0.
- Single step: step_mode = 1, start, then step pulses on three non-adjacent cycles -> exactly one new instruction per pulse (0, 1, 2); no change on other cycles.
- Asynchronous reset mid-run: drop n_reset between clock edges -> all outputs 0 and state IDLE before the next edge; no fetch until start.
